fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- RV64 instruction fetch stage, directly upstream of the instruction decoder.
- Generates sequential fetch PCs and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned {pc, instr} pairs in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects from branch/jump resolution: flushes buffered entries and discards in-flight responses.

Parameters:
- RESET_PC, 64'h0000_0000_0000_0000, fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries (power of two, >=2); also the cap on outstanding requests plus buffered entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  redirect fetch this cycle.
- redirect_pc  in  64  new fetch PC; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request.
- imem_addr  out  64  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after gnt.
- imem_rdata  in  32  response instruction word.
- if_valid  out  1  instruction available to decode.
- if_instr  out  32  instruction word to decoder.
- if_pc  out  64  PC of if_instr.
- if_ready  in  1  decode accepts this cycle.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low, and clears all state immediately on assertion.
- Reset values: fpc=RESET_PC, rpc=RESET_PC, outstanding=0, discard=0, FIFO empty, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- State:
  - fpc: next request address.
  - rpc: PC of the next kept response.
  - outstanding: granted requests not yet responded.
  - discard: stale responses still to drop.
  - Counter widths are $clog2(FIFO_DEPTH+1).
- Request issue:
  - imem_req = !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH).
  - imem_addr = {fpc[63:2], 2'b00}.
  - While imem_req=1 and gnt=0, the address is held stable. A redirect withdraws the request; the memory protocol permits withdrawal.
- On req&&gnt: fpc <= fpc+4, wrapping modulo 2^64; outstanding increments.
- On rvalid:
  - outstanding decrements.
  - If discard>0, the response is dropped and discard decrements.
  - Otherwise {rpc, rdata} is pushed and rpc <= rpc+4.
  - rvalid with outstanding==0 is ignored (checked by assertion).
- Simultaneous grant and response in one cycle: the net outstanding change is 0.
- Decode side:
  - if_valid = FIFO non-empty; if_instr/if_pc show the head entry and are forced to 0 when empty.
  - Pop on if_valid&&if_ready.
  - Latency: rvalid in cycle N gives if_valid in cycle N+1.
  - Sustained throughput is 1 instruction/cycle when memory grants every cycle.
- Overflow cannot occur: the credit rule guarantees a FIFO slot for every granted request. Push and pop may occur in the same cycle, including when the FIFO is full.
- Redirect (redirect_valid=1), which has priority over all other events in the same cycle:
  - FIFO flushed; any pop that cycle is cancelled (if_valid still shows the old head, but it is not consumed).
  - fpc <= redirect_pc & ~3 and rpc <= redirect_pc & ~3.
  - discard <= outstanding after this cycle's grant and response updates. A response arriving in the redirect cycle is dropped.
  - imem_req=0 that cycle; issue resumes next cycle at the new PC.
  - Back-to-back redirects: each one recomputes discard and reloads the PCs.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (64, counts if_valid&&if_ready) and perf_stall (64, counts cycles with if_ready=1 and if_valid=0). Both reset to 0, wrap modulo 2^64, and are unaffected by redirect.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package fetch_pkg holds:
  - XLEN=64, ILEN=32.
  - fetch_entry_t packed struct {pc[63:0], instr[31:0]}.
  - Default RESET_PC constant.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. Flush has priority over push and pop.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle response, if_ready=1 -> imem_addr 0x0,0x4,0x8...; if_pc 0x0,0x4,0x8 on consecutive cycles; if_valid first high 2 cycles after the first grant.
- if_ready=0 held, FIFO_DEPTH=4 -> exactly 4 grants, then imem_req=0; if_pc stays 0x0; on if_ready=1, the 4 entries drain, then requests resume at 0x10.
- 2 requests outstanding, redirect_pc=0x1002 -> next imem_addr 0x1000; both stale responses dropped; first if_pc=0x1000 with the matching rdata.
- Redirect in the same cycle as rvalid and if_valid&&if_ready -> response dropped, head not consumed, FIFO empty next cycle, discard equals remaining outstanding.
- fpc near the top, redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> addresses 0x...FFFC then 0x0; if_pc follows the same wrap.
- rst_n asserted mid-stream with 3 outstanding -> outputs return to reset values in the same cycle; after release, fetch restarts at RESET_PC and late rvalid pulses are ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the RV64 instruction fetch stage.
//   XLEN / ILEN      : address and instruction widths
//   fetch_entry_t    : {pc, instr} pair carried from memory response to decode
//   DEFAULT_RESET_PC : default fetch address after reset
//   word_align()     : clears the two byte-offset bits of an address
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & {{(XLEN-2){1'b1}}, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (clears pointers/count)
//   flush           : empty the FIFO; wins over push and pop in the same cycle
//   push, wdata     : write one entry
//   pop             : consume the head entry (caller only pops when non-empty)
//   rdata           : head entry (meaningless when empty)
//   count/empty/full: occupancy status
// Storage is not reset; only the pointers and count are.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CW         = $clog2(FIFO_DEPTH+1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   output fetch_entry_t rdata,
   output logic [CW-1:0] count,
   output logic         empty,
   output logic         full
);

   localparam int AW = $clog2(FIFO_DEPTH);

   fetch_entry_t  mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
   end

   // Push while full is legal only together with a pop: the write lands in the
   // slot being vacated, which is read combinationally before the edge.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wptr] <= wdata;
   end

   assign rdata = mem[rptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(FIFO_DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV64 instruction fetch stage feeding the decoder.
// Issues sequential word fetches over a req/gnt/rvalid memory interface,
// buffers {pc, instr} responses in a prefetch FIFO and hands them to decode
// with a valid/ready handshake. A redirect flushes the FIFO, reloads the
// fetch PC and drops every response still in flight.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      : branch/jump redirect (pc[1:0] ignored)
//   imem_req, imem_addr, imem_gnt    : request channel
//   imem_rvalid, imem_rdata          : in-order response channel
//   if_valid, if_instr, if_pc, if_ready : decode handshake
//   perf_fetched, perf_stall         : only with FETCH_PERF_CNT_EN defined
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters).
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [ILEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   input  logic            if_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_stall
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH+1);

   logic [XLEN-1:0] fpc;
   logic [XLEN-1:0] rpc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credits_used;
   logic            fifo_empty;
   logic            fifo_full;
   logic            gnt_fire;
   logic            rsp_fire;
   logic            keep_rsp;
   logic            pop;
   fetch_entry_t    head;
   fetch_entry_t    new_entry;

   // Every granted request owns a FIFO slot, so buffered + in-flight is capped.
   assign credits_used = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req     = rst_n && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
   assign imem_addr    = word_align(fpc);

   assign gnt_fire = imem_req && imem_gnt;
   // A response with nothing outstanding is spurious and ignored.
   assign rsp_fire = imem_rvalid && (outstanding != '0);
   assign keep_rsp = rsp_fire && (discard == '0) && !redirect_valid;
   assign pop      = !fifo_empty && if_ready && !redirect_valid;

   assign outstanding_nxt = outstanding + {{(CW-1){1'b0}}, gnt_fire}
                                        - {{(CW-1){1'b0}}, rsp_fire};

   assign new_entry = '{pc: rpc, instr: imem_rdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fpc         <= RESET_PC;
         rpc         <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            fpc     <= word_align(redirect_pc);
            rpc     <= word_align(redirect_pc);
            // Everything still in flight after this cycle belongs to the old path.
            discard <= outstanding_nxt;
         end else begin
            if (gnt_fire) fpc <= fpc + XLEN'(4);
            if (keep_rsp) rpc <= rpc + XLEN'(4);
            if (rsp_fire && (discard != '0)) discard <= discard - 1'b1;
         end
      end
   end

   fetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CW         (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (keep_rsp),
      .wdata (new_entry),
      .pop   (pop),
      .rdata (head),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign if_valid = !fifo_empty;
   assign if_instr = fifo_empty ? '0 : head.instr;
   assign if_pc    = fifo_empty ? '0 : head.pc;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (if_valid && if_ready)  perf_fetched <= perf_fetched + XLEN'(1);
         if (if_ready && !if_valid) perf_stall   <= perf_stall + XLEN'(1);
      end
   end
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(imem_rvalid && (outstanding == '0)))
            else $warning("fetch_unit: rvalid with no outstanding request ignored");
         assert (!(keep_rsp && fifo_full && !pop))
            else $error("fetch_unit: prefetch FIFO overflow");
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a queue-based
// reference model (buffered entries and in-flight requests as queues, each
// in-flight request tagged stale once a redirect overtakes it).
// Directed phases cover streaming, back-pressure, redirect with requests
// in flight, address wrap at the top of memory and reset mid-stream.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [63:0] if_pc;
   logic        if_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
   logic [63:0] perf_fetched;
   logic [63:0] perf_stall;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC   (64'h0),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_ready       (if_ready)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   typedef struct {
      logic [63:0] addr;
      bit          stale;
   } flight_t;

   flight_t      flight_q[$];
   fetch_entry_t buf_q[$];
   logic [63:0]  next_fetch;
   logic [63:0]  model_fetched;
   logic [63:0]  model_stall;

   int vectors = 0;
   int miscompares = 0;

   int          p_gnt, p_rsp, p_rdy, p_redir;
   bit          late_mode = 1'b0;
   bit          force_redir = 1'b0;
   logic [63:0] force_pc = '0;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      flight_q.delete();
      buf_q.delete();
      next_fetch    = 64'h0;
      model_fetched = '0;
      model_stall   = '0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 64'h0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 64'h0);
      chk("rst_if_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_perf_fetched", perf_fetched, 64'h0);
      chk("rst_perf_stall", perf_stall, 64'h0);
`endif
   endtask

   // One clock cycle: drive at the falling edge, check and advance the model
   // before the following rising edge.
   task automatic step();
      bit           redir, gnt, rsp, rdy, exp_req;
      flight_t      f;
      fetch_entry_t e;
      @(negedge clk);
      redir = force_redir || ($urandom_range(99) < p_redir);
      case ($urandom_range(3))
         0: redirect_pc = {$urandom, $urandom};
         1: redirect_pc = 64'h1002;
         2: redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
         default: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF5;
      endcase
      if (force_redir) redirect_pc = force_pc;
      force_redir    = 1'b0;
      redirect_valid = redir;
      gnt      = ($urandom_range(99) < p_gnt);
      imem_gnt = gnt;
      if (late_mode) begin
         rsp         = 1'b0;
         imem_rvalid = 1'b1;
         imem_rdata  = $urandom;
      end else begin
         rsp         = (flight_q.size() > 0) && ($urandom_range(99) < p_rsp);
         imem_rvalid = rsp;
         imem_rdata  = rsp ? mem_word(flight_q[0].addr) : $urandom;
      end
      rdy      = ($urandom_range(99) < p_rdy);
      if_ready = rdy;
      #1;
      exp_req = !redir && ((buf_q.size() + flight_q.size()) < DEPTH);
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, next_fetch);
      chk("if_valid", if_valid, buf_q.size() > 0);
      if (buf_q.size() > 0) begin
         chk("if_pc", if_pc, buf_q[0].pc);
         chk("if_instr", if_instr, buf_q[0].instr);
      end else begin
         chk("if_pc_empty", if_pc, 64'h0);
         chk("if_instr_empty", if_instr, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, model_fetched);
      chk("perf_stall", perf_stall, model_stall);
`endif
      if (rdy && buf_q.size() > 0)  model_fetched++;
      if (rdy && buf_q.size() == 0) model_stall++;

      if (rsp) f = flight_q.pop_front();
      if (redir) begin
         buf_q.delete();
         foreach (flight_q[i]) flight_q[i].stale = 1'b1;
         next_fetch = redirect_pc & ~64'd3;
      end else begin
         if (rdy && buf_q.size() > 0) void'(buf_q.pop_front());
         if (rsp && !f.stale) begin
            e.pc    = f.addr;
            e.instr = mem_word(f.addr);
            buf_q.push_back(e);
         end
         if (exp_req && gnt) begin
            flight_q.push_back('{addr: next_fetch, stale: 1'b0});
            next_fetch = next_fetch + 64'd4;
         end
      end
   endtask

   task automatic set_knobs(input int g, input int r, input int y, input int d);
      p_gnt = g; p_rsp = r; p_rdy = y; p_redir = d;
   endtask

   initial begin
      model_reset();
      #2;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Streaming at full rate.
      set_knobs(100, 100, 100, 0);
      repeat (20) step();

      // Back-pressure: FIFO fills, requests stop, then drain.
      set_knobs(100, 100, 0, 0);
      repeat (10) step();
      set_knobs(100, 100, 100, 0);
      repeat (10) step();

      // Redirect with requests in flight.
      set_knobs(100, 0, 100, 0);
      repeat (2) step();
      force_redir = 1'b1;
      force_pc    = 64'h1002;
      step();
      set_knobs(100, 100, 100, 0);
      repeat (12) step();

      // Wrap at the top of the address space.
      force_redir = 1'b1;
      force_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      repeat (10) step();

      // Random traffic with redirects.
      set_knobs(70, 60, 70, 6);
      repeat (3000) step();

      // Reset mid-stream with requests outstanding.
      set_knobs(100, 0, 100, 0);
      repeat (3) step();
      @(posedge clk);
      #2;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      if_ready       = 1'b0;
      #1;
      check_reset_outputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Late responses after reset are ignored.
      late_mode = 1'b1;
      set_knobs(0, 0, 100, 0);
      repeat (3) step();
      late_mode = 1'b0;
      set_knobs(80, 80, 80, 0);
      repeat (40) step();
      set_knobs(70, 60, 70, 6);
      repeat (500) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
